// File: rtl/riscv_dtm_dmi.sv
// RISC-V JTAG Debug Transport Module (debug spec 0.13): IDCODE/DTMCS/DMI/BYPASS
// data registers bridging DMI scans to a valid/ready request/response Debug Module port.
module riscv_dtm_dmi #(
  parameter logic [31:0] IDCODE      = 32'h1DEAD3FF,
  parameter int unsigned ABITS       = 7,
  parameter int unsigned IDLE_CYCLES = 0
) (
  input  logic             tck_i,
  input  logic             trst_i,
  input  logic             tdi_i,
  output logic             tdo_o,
  input  logic             capture_dr_i,
  input  logic             shift_dr_i,
  input  logic             update_dr_i,
  input  logic [4:0]       ir_i,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [31:0]      dmi_req_data_o,
  output logic [1:0]       dmi_req_op_o,
  input  logic             dmi_resp_valid_i,
  output logic             dmi_resp_ready_o,
  input  logic [31:0]      dmi_resp_data_i,
  input  logic [1:0]       dmi_resp_op_i
);

  localparam int unsigned DMI_W     = ABITS + 34;
  localparam logic [4:0]  IR_IDCODE = 5'h01;
  localparam logic [4:0]  IR_DTMCS  = 5'h10;
  localparam logic [4:0]  IR_DMI    = 5'h11;
  localparam logic [1:0]  OP_READ   = 2'd1;
  localparam logic [1:0]  OP_WRITE  = 2'd2;
  localparam logic [1:0]  ST_FAILED = 2'd2;
  localparam logic [1:0]  ST_BUSY   = 2'd3;
  localparam logic [2:0]  IDLE_F    = 3'(IDLE_CYCLES);
  localparam logic [5:0]  ABITS_F   = 6'(ABITS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sticky_q, sticky_d;
  logic             resp_ready_q;

  logic [31:0]      idcode_shift;
  logic [31:0]      dtmcs_shift;
  logic [DMI_W-1:0] dmi_shift;
  logic             bypass_shift;

  logic [ABITS-1:0] last_addr_q, req_addr_q;
  logic [31:0]      last_data_q, req_data_q;
  logic [1:0]       req_op_q;

  logic             sel_dmi, sel_dtmcs;
  logic             resp_done, busy, issue;
  logic             dmi_reset, dmi_hard_reset;
  logic [ABITS-1:0] upd_addr;
  logic [31:0]      upd_data;
  logic [1:0]       upd_op;
  logic [31:0]      dtmcs_cap;
  logic [1:0]       dmi_cap_op;

  assign sel_dmi   = (ir_i == IR_DMI);
  assign sel_dtmcs = (ir_i == IR_DTMCS);

  // A response completing on this edge frees the DTM for a capture/update on the same edge.
  assign resp_done = (state_q == S_RESP) && dmi_resp_valid_i;
  assign busy      = (state_q != S_IDLE) && !resp_done;

  assign upd_addr = dmi_shift[DMI_W-1 -: ABITS];
  assign upd_data = dmi_shift[33:2];
  assign upd_op   = dmi_shift[1:0];

  assign issue = update_dr_i && sel_dmi && !busy && (sticky_q == 2'd0) &&
                 ((upd_op == OP_READ) || (upd_op == OP_WRITE));

  assign dmi_hard_reset = update_dr_i && sel_dtmcs && dtmcs_shift[17];
  assign dmi_reset      = update_dr_i && sel_dtmcs && dtmcs_shift[16];

  assign dtmcs_cap  = {14'b0, 2'b0, 1'b0, IDLE_F, sticky_q, ABITS_F, 4'd1};
  assign dmi_cap_op = busy ? ST_BUSY : sticky_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d  = state_q;
    sticky_d = sticky_q;

    case (state_q)
      S_IDLE:  if (issue) state_d = S_REQ;
      S_REQ:   if (dmi_req_ready_i) state_d = S_RESP;
      S_RESP:  if (dmi_resp_valid_i) state_d = issue ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (dmi_hard_reset) state_d = S_IDLE;

    // Only the first error is recorded; later events never overwrite a nonzero sticky.
    if (resp_done && (sticky_q == 2'd0) && (dmi_resp_op_i != 2'd0))
      sticky_d = (dmi_resp_op_i == ST_BUSY) ? ST_BUSY : ST_FAILED;
    if (busy && sel_dmi && (capture_dr_i || update_dr_i) && (sticky_q == 2'd0))
      sticky_d = ST_BUSY;
    if (dmi_reset || dmi_hard_reset) sticky_d = 2'd0;
  end

  always_ff @(posedge tck_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (trst_i) begin
      state_q      <= S_IDLE;
      sticky_q     <= 2'd0;
      resp_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sticky_q     <= sticky_d;
      resp_ready_q <= (state_d != S_REQ);
    end
  end

  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      idcode_shift <= IDCODE;
      dtmcs_shift  <= '0;
      dmi_shift    <= '0;
      bypass_shift <= 1'b0;
    end else if (capture_dr_i) begin
      case (ir_i)
        IR_IDCODE: idcode_shift <= IDCODE;
        IR_DTMCS:  dtmcs_shift  <= dtmcs_cap;
        IR_DMI:    dmi_shift    <= {last_addr_q, last_data_q, dmi_cap_op};
        default:   bypass_shift <= 1'b0;
      endcase
    end else if (shift_dr_i) begin
      case (ir_i)
        IR_IDCODE: idcode_shift <= {tdi_i, idcode_shift[31:1]};
        IR_DTMCS:  dtmcs_shift  <= {tdi_i, dtmcs_shift[31:1]};
        IR_DMI:    dmi_shift    <= {tdi_i, dmi_shift[DMI_W-1:1]};
        default:   bypass_shift <= tdi_i;
      endcase
    end
  end

  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_op_q    <= 2'd0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      if (resp_done && (dmi_resp_op_i == 2'd0) && (req_op_q == OP_READ))
        last_data_q <= dmi_resp_data_i;
      if (issue) begin
        req_addr_q  <= upd_addr;
        req_data_q  <= upd_data;
        req_op_q    <= upd_op;
        last_addr_q <= upd_addr;
        if (upd_op == OP_WRITE) last_data_q <= upd_data;
      end
    end
  end

  always_comb begin
    tdo_o = bypass_shift;
    case (ir_i)
      IR_IDCODE: tdo_o = idcode_shift[0];
      IR_DTMCS:  tdo_o = dtmcs_shift[0];
      IR_DMI:    tdo_o = dmi_shift[0];
      default:   tdo_o = bypass_shift;
    endcase
  end

  assign dmi_req_valid_o  = (state_q == S_REQ);
  assign dmi_req_addr_o   = req_addr_q;
  assign dmi_req_data_o   = req_data_q;
  assign dmi_req_op_o     = req_op_q;
  assign dmi_resp_ready_o = resp_ready_q;

endmodule

// File: tb/tb_riscv_dtm_dmi.sv
// Directed bench for riscv_dtm_dmi: DR scans driven through the TAP strobes,
// with a cycle-stepped Debug Module model answering DMI requests.
module tb_riscv_dtm_dmi;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;

  typedef struct {
    string       name;
    logic [4:0]  ir;
    int          width;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  logic        tck = 1'b0;
  logic        trst = 1'b1;
  logic        tdi = 1'b0;
  logic        capture = 1'b0, shift = 1'b0, update = 1'b0;
  logic [4:0]  ir = 5'h01;

  logic        tdo, dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_ready;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data, dmi_resp_data;
  logic [1:0]  dmi_req_op, dmi_resp_op;

  logic        tdo5, req_valid5, resp_ready5;
  logic        req_ready5 = 1'b0, resp_valid5 = 1'b0;
  logic [4:0]  req_addr5;
  logic [31:0] req_data5, resp_data5 = 32'd0;
  logic [1:0]  req_op5, resp_op5 = 2'd0;

  int n_checks = 0;
  int n_fail   = 0;

  // Debug Module model state
  int          beats = 0, resps = 0, rdy_cnt = 0, rsp_cnt = 0;
  int          dm_ready_delay = 0, dm_resp_delay = 0;
  bit          pending = 0, dm_hold = 0, dm_fire = 0, dm_ready_en = 1;
  logic [31:0] dm_resp_data = 32'd0;
  logic [1:0]  dm_resp_op = 2'd0;
  logic [6:0]  beat_addr = '0;
  logic [31:0] beat_data = '0;
  logic [1:0]  beat_op = '0;
  logic        resp_ready_seen = 1'b0;

  riscv_dtm_dmi #(.IDCODE(32'h1DEAD3FF), .ABITS(7), .IDLE_CYCLES(0)) dut (
    .tck_i(tck), .trst_i(trst), .tdi_i(tdi), .tdo_o(tdo),
    .capture_dr_i(capture), .shift_dr_i(shift), .update_dr_i(update), .ir_i(ir),
    .dmi_req_valid_o(dmi_req_valid), .dmi_req_ready_i(dmi_req_ready),
    .dmi_req_addr_o(dmi_req_addr), .dmi_req_data_o(dmi_req_data), .dmi_req_op_o(dmi_req_op),
    .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(dmi_resp_ready),
    .dmi_resp_data_i(dmi_resp_data), .dmi_resp_op_i(dmi_resp_op)
  );

  riscv_dtm_dmi #(.IDCODE(32'h1DEAD3FF), .ABITS(5), .IDLE_CYCLES(0)) dut5 (
    .tck_i(tck), .trst_i(trst), .tdi_i(tdi), .tdo_o(tdo5),
    .capture_dr_i(capture), .shift_dr_i(shift), .update_dr_i(update), .ir_i(ir),
    .dmi_req_valid_o(req_valid5), .dmi_req_ready_i(req_ready5),
    .dmi_req_addr_o(req_addr5), .dmi_req_data_o(req_data5), .dmi_req_op_o(req_op5),
    .dmi_resp_valid_i(resp_valid5), .dmi_resp_ready_o(resp_ready5),
    .dmi_resp_data_i(resp_data5), .dmi_resp_op_i(resp_op5)
  );

  always #5 tck = ~tck;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    return {23'd0, a, d, op};
  endfunction

  // One DM decision per cycle, made at the falling edge for the next rising edge.
  task automatic dm_step();
    dmi_req_ready  = 1'b0;
    dmi_resp_valid = 1'b0;
    if (trst) begin
      pending = 0; rdy_cnt = 0; rsp_cnt = 0;
    end else if (!pending) begin
      if (dmi_req_valid && dm_ready_en) begin
        if (rdy_cnt >= dm_ready_delay) begin
          dmi_req_ready = 1'b1;
          beats++;
          beat_addr = dmi_req_addr; beat_data = dmi_req_data; beat_op = dmi_req_op;
          pending = 1; rdy_cnt = 0; rsp_cnt = 0;
        end else rdy_cnt++;
      end else rdy_cnt = 0;
    end else if (dm_fire || (!dm_hold && rsp_cnt >= dm_resp_delay)) begin
      dmi_resp_valid  = 1'b1;
      dmi_resp_data   = dm_resp_data;
      dmi_resp_op     = dm_resp_op;
      resp_ready_seen = dmi_resp_ready;
      resps++;
      pending = 0;
      dm_fire = 0;
    end else rsp_cnt++;
  endtask

  task automatic tick();
    dm_step();
    @(negedge tck);
  endtask

  task automatic scan(input logic [4:0] irv, input int width, input logic [63:0] din,
                      input bit five, input bit fire, output logic [63:0] dout);
    dout    = '0;
    ir      = irv;
    capture = 1'b1;
    dm_fire = fire;
    tick();
    dm_fire = 0;
    capture = 1'b0;
    shift   = 1'b1;
    for (int i = 0; i < width; i++) begin
      tdi     = din[i];
      dout[i] = five ? tdo5 : tdo;
      tick();
    end
    shift  = 1'b0;
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic wait_for(input string name, input bit on_beats, input int target);
    int n = 0;
    while (((on_beats ? beats : resps) < target) && (n < 200)) begin
      tick();
      n++;
    end
    check(name, 64'((on_beats ? beats : resps) >= target), 64'd1);
  endtask

  initial begin
    vec_t        vecs[6];
    logic [63:0] d;

    vecs[0] = '{"idcode",     IR_IDCODE, 32, 64'd0, 64'h1DEAD3FF};
    vecs[1] = '{"idcode_len", IR_IDCODE, 33, 64'd1, 64'h1_1DEAD3FF};
    vecs[2] = '{"dtmcs",      IR_DTMCS,  32, 64'd0, 64'h71};
    vecs[3] = '{"bypass_1f",  5'h1F,      2, 64'd3, 64'h2};
    vecs[4] = '{"bypass_00",  5'h00,      2, 64'd1, 64'h2};
    vecs[5] = '{"dmi_len",    IR_DMI,    42, 64'd1, 64'h200_0000_0000};

    @(negedge tck);
    tick(); tick();
    check("rst_req_valid",  dmi_req_valid, 0);
    check("rst_resp_ready", dmi_resp_ready, 0);
    check("rst_req_fields", {dmi_req_addr, dmi_req_data, dmi_req_op}, 0);
    trst = 1'b0;
    tick();
    check("idle_resp_ready", dmi_resp_ready, 1);

    for (int i = 0; i < 6; i++) begin
      scan(vecs[i].ir, vecs[i].width, vecs[i].din, 0, 0, d);
      check(vecs[i].name, d, vecs[i].exp);
    end

    // Write, DM ready after 3 cycles, ok response
    dm_ready_delay = 3;
    scan(IR_DMI, 41, mk(7'h10, 32'h80000001, 2'd2), 0, 0, d);
    wait_for("wr_resp", 0, 1);
    repeat (3) tick();
    check("wr_beats", beats, 1);
    check("wr_beat", {beat_addr, beat_data, beat_op}, {7'h10, 32'h80000001, 2'd2});
    scan(IR_DMI, 41, 64'd0, 0, 0, d);
    check("wr_capture", d, mk(7'h10, 32'h80000001, 2'd0));

    // Read with returned data
    dm_ready_delay = 0;
    dm_resp_data   = 32'h00400382;
    scan(IR_DMI, 41, mk(7'h11, 32'd0, 2'd1), 0, 0, d);
    wait_for("rd_resp", 0, 2);
    check("rd_resp_ready", resp_ready_seen, 1);
    check("rd_beat", {beat_addr, beat_op}, {7'h11, 2'd1});
    scan(IR_DMI, 41, 64'd0, 0, 0, d);
    check("rd_capture", d, mk(7'h11, 32'h00400382, 2'd0));

    // Withheld response: busy reporting, ignored updates, dmireset
    dm_hold      = 1;
    dm_resp_data = 32'h12345678;
    scan(IR_DMI, 41, mk(7'h12, 32'd0, 2'd1), 0, 0, d);
    wait_for("busy_beat", 1, 3);
    scan(IR_DMI, 41, 64'd0, 0, 0, d);
    check("busy_capture", d, mk(7'h12, 32'h00400382, 2'd3));
    scan(IR_DTMCS, 32, 64'd0, 0, 0, d);
    check("busy_dtmcs", d, 64'hC71);
    scan(IR_DMI, 41, mk(7'h13, 32'd5, 2'd2), 0, 0, d);
    repeat (5) tick();
    check("busy_no_req", beats, 3);
    scan(IR_DTMCS, 32, 64'h10000, 0, 0, d);
    check("dmireset_capture", d, 64'hC71);
    scan(IR_DTMCS, 32, 64'd0, 0, 0, d);
    check("dmireset_cleared", d, 64'h71);
    check("still_resp", {dmi_req_valid, dmi_resp_ready}, 2'b01);
    dm_hold = 0;
    wait_for("late_resp", 0, 3);
    scan(IR_DMI, 41, mk(7'h14, 32'hCAFEF00D, 2'd2), 0, 0, d);
    wait_for("after_reset_resp", 0, 4);
    check("after_reset_beat", {beat_addr, beat_data}, {7'h14, 32'hCAFEF00D});

    // Failed response, then hardreset of a held request
    dm_resp_op = 2'd2;
    scan(IR_DMI, 41, mk(7'h15, 32'd1, 2'd2), 0, 0, d);
    wait_for("fail_resp", 0, 5);
    scan(IR_DTMCS, 32, 64'd0, 0, 0, d);
    check("fail_dtmcs", d, 64'h871);
    scan(IR_DMI, 41, mk(7'h16, 32'd2, 2'd2), 0, 0, d);
    repeat (5) tick();
    check("fail_no_req", beats, 5);
    scan(IR_DMI, 41, 64'd0, 0, 0, d);
    check("fail_capture", d, mk(7'h15, 32'd1, 2'd2));
    scan(IR_DTMCS, 32, 64'h10000, 0, 0, d);
    dm_resp_op  = 2'd0;
    dm_ready_en = 0;
    scan(IR_DMI, 41, mk(7'h17, 32'd3, 2'd2), 0, 0, d);
    check("held_req", {dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}, {1'b1, 7'h17, 32'd3, 2'd2});
    scan(IR_DTMCS, 32, 64'h20000, 0, 0, d);
    check("hardreset_drop", {dmi_req_valid, dmi_resp_ready}, 2'b01);
    scan(IR_DTMCS, 32, 64'd0, 0, 0, d);
    check("hardreset_dtmcs", d, 64'h71);
    dm_ready_en  = 1;
    dm_resp_data = 32'h55AA55AA;
    scan(IR_DMI, 41, mk(7'h1A, 32'd0, 2'd1), 0, 0, d);
    wait_for("post_hard_resp", 0, 6);
    check("post_hard_beat", {beats, beat_addr}, {32'd6, 7'h1A});

    // Capture on the same edge as the completing response
    dm_hold      = 1;
    dm_resp_data = 32'hA5A5A5A5;
    scan(IR_DMI, 41, mk(7'h18, 32'd0, 2'd1), 0, 0, d);
    wait_for("coinc_beat", 1, 7);
    scan(IR_DMI, 41, 64'd0, 0, 1, d);
    check("coinc_capture", {d[40:34], d[1:0]}, {7'h18, 2'd0});
    check("coinc_resps", resps, 7);
    dm_hold = 0;
    scan(IR_DTMCS, 32, 64'd0, 0, 0, d);
    check("coinc_dtmcs", d, 64'h71);
    scan(IR_DMI, 41, 64'd0, 0, 0, d);
    check("coinc_data", d, mk(7'h18, 32'hA5A5A5A5, 2'd0));

    // Reset while a request is outstanding
    dm_ready_en = 0;
    scan(IR_DMI, 41, mk(7'h19, 32'd7, 2'd2), 0, 0, d);
    check("pre_rst_valid", dmi_req_valid, 1);
    trst = 1'b1;
    tick();
    check("mid_rst_outputs", {dmi_req_valid, dmi_resp_ready, dmi_req_addr, dmi_req_data, dmi_req_op}, 0);
    trst = 1'b0;
    tick();
    check("post_rst_idle", {dmi_req_valid, dmi_resp_ready}, 2'b01);
    dm_ready_en = 1;
    scan(IR_DTMCS, 32, 64'd0, 0, 0, d);
    check("post_rst_dtmcs", d, 64'h71);
    scan(IR_DMI, 41, 64'd0, 0, 0, d);
    check("post_rst_dmi", d, 64'd0);
    check("post_rst_beats", beats, 7);

    // ABITS=5 instance
    scan(IR_DTMCS, 32, 64'd0, 1, 0, d);
    check("a5_dtmcs", d, 64'h51);
    scan(IR_DMI, 40, 64'd1, 1, 0, d);
    check("a5_dmi_len", d, 64'h80_0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
